// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared decode constants, FSM state type and field helpers for the 19-bit core.
// Used by the hazard controller and the forwarding unit.
package hazard_stall_ctrl_pkg;

  localparam int INSTR_W = 19;

  localparam int OP_MSB  = 18;
  localparam int OP_LSB  = 14;
  localparam int DST_MSB = 13;
  localparam int DST_LSB = 11;
  localparam int A_MSB   = 10;
  localparam int A_LSB   = 8;
  localparam int B_MSB   = 7;
  localparam int B_LSB   = 5;

  localparam logic [4:0] OP_LW = 5'b10000;
  localparam logic [4:0] OP_SW = 5'b10001;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } ctrl_state_t;

  function automatic logic [4:0] op_of(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [2:0] dst_of(input logic [INSTR_W-1:0] instr);
    return instr[DST_MSB:DST_LSB];
  endfunction

  function automatic logic [2:0] a_of(input logic [INSTR_W-1:0] instr);
    return instr[A_MSB:A_LSB];
  endfunction

  function automatic logic [2:0] b_of(input logic [INSTR_W-1:0] instr);
    return instr[B_MSB:B_LSB];
  endfunction

  function automatic logic is_alu(input logic [INSTR_W-1:0] instr);
    return ~instr[OP_MSB];
  endfunction

  // Only meaningful for ALU opcodes: selects the immediate form, so B is not a register.
  function automatic logic is_imm(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB-1];
  endfunction

  function automatic logic is_mem(input logic [INSTR_W-1:0] instr);
    return (op_of(instr) == OP_LW) || (op_of(instr) == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Combinational load-use detector: flags a hazard between the LW in EX and the
// instruction in ID and reports whether two bubbles are needed instead of one.
module hazard_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] id_instr,
  input  logic [INSTR_W-1:0] ex_instr,
  output logic               hazard,
  output logic               need_two
);

  logic       load_in_ex;
  logic [2:0] load_dst;
  logic       alu_use;
  logic       mem_use;
  logic       unused_bits;

  assign unused_bits = ^{id_instr[4:0], ex_instr[10:0]};

  // Memory-op consumers have no forwarding path from a load, hence the second bubble.
  always_comb begin
    load_in_ex = (op_of(ex_instr) == OP_LW);
    load_dst   = dst_of(ex_instr);
    alu_use    = is_alu(id_instr) &&
                 ((a_of(id_instr) == load_dst) ||
                  (!is_imm(id_instr) && (b_of(id_instr) == load_dst)));
    mem_use    = is_mem(id_instr) &&
                 ((a_of(id_instr) == load_dst) ||
                  ((op_of(id_instr) == OP_SW) && (dst_of(id_instr) == load_dst)));
    hazard     = load_in_ex && (load_dst != 3'd0) && (alu_use || mem_use);
    need_two   = mem_use;
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch squash and memory freeze.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
`ifdef HAZARD_PERF_CNT_EN
  #(parameter int CNT_W = 16)
`endif
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] IF_ID_instruction,
  input  logic [INSTR_W-1:0] ID_EX_instruction,
  input  logic [INSTR_W-1:0] EX_MEM_instruction,
  input  logic               branch_taken,
  input  logic               dmem_ready,
  output logic               pc_write,
  output logic               IF_ID_write,
  output logic               IF_ID_flush,
  output logic               ID_EX_write,
  output logic               ID_EX_flush,
  output logic               EX_MEM_write,
  output logic               MEM_WB_flush,
  output logic [1:0]         ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_count,
  output logic [CNT_W-1:0]   mem_wait_cycles
`endif
);

  ctrl_state_t state, state_n, ret_state, ret_state_n, eff_state;
  logic [1:0]  remain, remain_n;
  logic        hazard, need_two, freeze;
  logic        mem_unused;

  hazard_detect u_detect (
    .id_instr (IF_ID_instruction),
    .ex_instr (ID_EX_instruction),
    .hazard   (hazard),
    .need_two (need_two)
  );

  assign mem_unused = ^EX_MEM_instruction[13:0];
  assign freeze     = is_mem(EX_MEM_instruction) && !dmem_ready;
  // Leaving MEM_WAIT behaves exactly like the state that was interrupted.
  assign eff_state  = (state == MEM_WAIT) ? ret_state : state;
  assign ctrl_state = state;

  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_write  = 1'b1;
    ID_EX_flush  = 1'b0;
    EX_MEM_write = 1'b1;
    MEM_WB_flush = 1'b0;
    state_n      = state;
    remain_n     = remain;
    ret_state_n  = ret_state;
    if (rst) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_write  = 1'b0;
      ID_EX_flush  = 1'b1;
      EX_MEM_write = 1'b0;
      MEM_WB_flush = 1'b1;
    end else if (freeze) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_flush = 1'b1;
      state_n      = MEM_WAIT;
      if (state != MEM_WAIT) ret_state_n = state;
    end else if (branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      state_n     = RUN;
      remain_n    = 2'd0;
    end else if (eff_state == LOAD_STALL) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
      remain_n    = remain - 2'd1;
      state_n     = (remain == 2'd1) ? RUN : LOAD_STALL;
    end else if (hazard) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
      if (need_two) begin
        state_n  = LOAD_STALL;
        remain_n = 2'd1;
      end else begin
        state_n  = RUN;
      end
    end else begin
      state_n = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      remain    <= 2'd0;
      ret_state <= RUN;
    end else begin
      state     <= state_n;
      remain    <= remain_n;
      ret_state <= ret_state_n;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_evt, squash_evt, wait_evt;

  assign wait_evt   = freeze;
  assign squash_evt = !freeze && branch_taken;
  assign stall_evt  = !freeze && !branch_taken && ((eff_state == LOAD_STALL) || hazard);

  // Counters saturate rather than wrap so long runs never report small values.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles    <= '0;
      flush_count     <= '0;
      mem_wait_cycles <= '0;
    end else begin
      if (stall_evt && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (squash_evt && (flush_count != '1)) flush_count <= flush_count + 1'b1;
      if (wait_evt && (mem_wait_cycles != '1)) mem_wait_cycles <= mem_wait_cycles + 1'b1;
    end
  end
`endif

endmodule
